// File: rtl/mem_pkg.sv
// Shared definitions for the block-transfer engine and its memory port.
package mem_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port word memory bus: combinational read, synchronous write.
interface mem_copy_engine_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  // Initiator side (the copy engine).
  modport master (
    output mem_address,
    output mem_write_data,
    output mem_write,
    input  mem_read_data
  );

  // Target side (the memory).
  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_write,
    output mem_read_data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-transfer initiator: copies or fills `length` words over a single
// memory port, one word per RD/WR pair (copy) or per WR (fill).
module mem_copy_engine #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);
  import mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q,   src_d;
  logic [ADDR_W-1:0] dst_q,   dst_d;
  logic [ADDR_W-1:0] rem_q,   rem_d;
  logic              mode_q,  mode_d;
  logic [DATA_W-1:0] fill_q,  fill_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-state logic: command load on accept, pointer/count update per write.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = length;
          mode_d = mode;
          fill_d = fill_value;
          if (length == '0)          state_d = DONE;
          else if (mode == MODE_FILL) state_d = WR;
          else                        state_d = RD;
        end
      end
      RD: begin
        data_d  = mem_read_data;
        state_d = WR;
      end
      WR: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        if (rem_q > ADDR_W'(1)) state_d = (mode_q == MODE_FILL) ? WR : RD;
        else                    state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and command registers; synchronous reset drops any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Output decode from registered state only; bus is parked at zero when idle.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    unique case (state_q)
      RD: begin
        busy        = 1'b1;
        mem_address = src_q;
      end
      WR: begin
        busy           = 1'b1;
        mem_address    = dst_q;
        mem_write_data = (mode_q == MODE_FILL) ? fill_q : data_q;
        mem_write      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural word memory.
module tb_mem_copy_engine;
  import mem_pkg::*;

  localparam int AW = mem_pkg::ADDR_W;
  localparam int DW = mem_pkg::DATA_W;
  localparam logic [AW-1:0] WIN_BASE = 19'h7FFE0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, mode;
  logic [AW-1:0] src_addr, dst_addr, length;
  logic [DW-1:0] fill_value;
  logic          busy, done;

  mem_copy_engine_if mem_bus ();

  // Behavioural memory plus a backdoor write port for preloading.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  assign mem_bus.mem_read_data = mem[mem_bus.mem_address];

  always @(posedge clk) begin
    if (mem_bus.mem_write) mem[mem_bus.mem_address] <= mem_bus.mem_write_data;
    else if (bd_we)        mem[bd_addr] <= bd_data;
  end

  mem_copy_engine dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .fill_value     (fill_value),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_bus.mem_address),
    .mem_write_data (mem_bus.mem_write_data),
    .mem_write      (mem_bus.mem_write),
    .mem_read_data  (mem_bus.mem_read_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Issue one command and observe it until done (bounded).
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] f,
                         output int done_cyc, output int writes, output int busy_cyc);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = l; fill_value = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1; writes = 0; busy_cyc = 0;
    for (int c = 1; c <= 2 * int'(l) + 10; c++) begin
      @(negedge clk);
      if (mem_bus.mem_write) writes++;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  typedef struct {
    string         name;
    logic          mode;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] fill;
    int            exp_done;
    int            exp_writes;
    int            exp_busy;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  vec_t  vecs [5];
  word_t pre  [$];
  word_t post [$];

  logic [DW-1:0] ref_win [64];

  initial begin
    int dc, wr, bc, cnt;
    logic [AW-1:0] a;

    rst = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    vecs[0] = '{"copy4",    MODE_COPY, 19'h00100, 19'h00200, 19'd4, 19'h0,     9, 4, 8};
    vecs[1] = '{"fillwrap", MODE_FILL, 19'h00000, 19'h7FFFE, 19'd4, 19'h5A5A5, 5, 4, 4};
    vecs[2] = '{"len0",     MODE_COPY, 19'h00020, 19'h00030, 19'd0, 19'h0,     1, 0, 0};
    vecs[3] = '{"overlap",  MODE_COPY, 19'h00010, 19'h00011, 19'd2, 19'h0,     5, 2, 4};
    vecs[4] = '{"fill1",    MODE_FILL, 19'h00000, 19'h00040, 19'd1, 19'h7FFFF, 2, 1, 1};

    pre = '{'{19'h00100, 19'd1}, '{19'h00101, 19'd2}, '{19'h00102, 19'd3}, '{19'h00103, 19'd4},
            '{19'h00200, 19'd0}, '{19'h00201, 19'd0}, '{19'h00202, 19'd0}, '{19'h00203, 19'd0},
            '{19'h7FFFD, 19'h1111}, '{19'h7FFFE, 19'd0}, '{19'h7FFFF, 19'd0},
            '{19'h00000, 19'd0}, '{19'h00001, 19'd0}, '{19'h00002, 19'h1111},
            '{19'h00010, 19'd7}, '{19'h00011, 19'd8}, '{19'h00012, 19'd9},
            '{19'h00030, 19'h3333}, '{19'h00040, 19'd0}};

    post = '{'{19'h00200, 19'd1}, '{19'h00201, 19'd2}, '{19'h00202, 19'd3}, '{19'h00203, 19'd4},
             '{19'h00100, 19'd1}, '{19'h00103, 19'd4},
             '{19'h7FFFE, 19'h5A5A5}, '{19'h7FFFF, 19'h5A5A5},
             '{19'h00000, 19'h5A5A5}, '{19'h00001, 19'h5A5A5},
             '{19'h7FFFD, 19'h1111}, '{19'h00002, 19'h1111},
             '{19'h00030, 19'h3333}, '{19'h00010, 19'd7}, '{19'h00011, 19'd7},
             '{19'h00012, 19'd7}, '{19'h00040, 19'h7FFFF}};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_write", {31'd0, mem_bus.mem_write}, 32'd0);
    check("rst_mem_address", 32'(mem_bus.mem_address), 32'd0);
    check("rst_mem_write_data", 32'(mem_bus.mem_write_data), 32'd0);

    // Directed table
    foreach (pre[i]) preload(pre[i].addr, pre[i].data);
    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, dc, wr, bc);
      check({vecs[i].name, "_done_cycle"}, 32'(dc), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_writes"}, 32'(wr), 32'(vecs[i].exp_writes));
      check({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'(vecs[i].exp_busy));
    end
    foreach (post[i]) check($sformatf("mem_0x%05h", post[i].addr), 32'(mem[post[i].addr]), 32'(post[i].data));

    // Start during busy is ignored; start during DONE chains with no gap
    preload(19'h00300, 19'h00AAA); preload(19'h00301, 19'h00BBB); preload(19'h00302, 19'h00CCC);
    preload(19'h00600, 19'h11111); preload(19'h00700, 19'h0); preload(19'h00701, 19'h0);
    @(negedge clk);
    mode = MODE_COPY; src_addr = 19'h00300; dst_addr = 19'h00400; length = 19'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin
        mode = MODE_FILL; src_addr = 19'h00500; dst_addr = 19'h00600;
        length = 19'd2; fill_value = 19'h3FFFF; start = 1'b1;
      end else if (c == 4) begin
        start = 1'b0;
      end
      if (done) begin
        dc = c;
        mode = MODE_FILL; dst_addr = 19'h00700; length = 19'd2;
        fill_value = 19'h12345; start = 1'b1;
        break;
      end
    end
    check("ignore_start_done_cycle", 32'(dc), 32'd7);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_c1_busy", {31'd0, busy}, 32'd1);
    check("b2b_c1_mem_write", {31'd0, mem_bus.mem_write}, 32'd1);
    check("b2b_c1_addr", 32'(mem_bus.mem_address), 32'h700);
    check("b2b_c1_wdata", 32'(mem_bus.mem_write_data), 32'h12345);
    @(negedge clk);
    check("b2b_c2_addr", 32'(mem_bus.mem_address), 32'h701);
    @(negedge clk);
    check("b2b_c3_done", {31'd0, done}, 32'd1);
    check("b2b_mem_400", 32'(mem[19'h00400]), 32'h00AAA);
    check("b2b_mem_401", 32'(mem[19'h00401]), 32'h00BBB);
    check("b2b_mem_402", 32'(mem[19'h00402]), 32'h00CCC);
    check("b2b_mem_600_untouched", 32'(mem[19'h00600]), 32'h11111);
    check("b2b_mem_701", 32'(mem[19'h00701]), 32'h12345);

    // Reset in cycle 3 of an 8-word copy
    for (int i = 0; i < 8; i++) begin
      preload(19'h00800 + AW'(i), 19'h00100 + DW'(i));
      preload(19'h00900 + AW'(i), 19'h0);
    end
    @(negedge clk);
    mode = MODE_COPY; src_addr = 19'h00800; dst_addr = 19'h00900; length = 19'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_mem_write", {31'd0, mem_bus.mem_write}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || mem_bus.mem_write) cnt++;
    end
    check("midrst_quiet_cycles", 32'(cnt), 32'd0);
    check("midrst_mem_900", 32'(mem[19'h00900]), 32'h00100);
    check("midrst_mem_901", 32'(mem[19'h00901]), 32'h0);

    // Reset and start together: command dropped
    preload(19'h00A00, 19'h00099);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mode = MODE_FILL; dst_addr = 19'h00A00;
    length = 19'd3; fill_value = 19'h00055;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || mem_bus.mem_write) cnt++;
    end
    check("rst_start_quiet_cycles", 32'(cnt), 32'd0);
    check("rst_start_mem_a00", 32'(mem[19'h00A00]), 32'h00099);

    // Randomized commands in a 64-word window straddling the address wrap
    for (int k = 0; k < 64; k++) begin
      ref_win[k] = DW'($urandom);
      preload(WIN_BASE + AW'(k), ref_win[k]);
    end
    for (int n = 0; n < 12; n++) begin
      int so, dof, len, exp_done;
      logic m;
      logic [DW-1:0] fv;
      so  = int'($urandom_range(0, 31));
      dof = int'($urandom_range(0, 31));
      len = int'($urandom_range(0, 32));
      m   = 1'($urandom_range(0, 1));
      fv  = DW'($urandom);
      // Reference: ascending word-by-word transfer, re-reading already written words
      for (int i = 0; i < len; i++)
        ref_win[dof + i] = (m == MODE_FILL) ? fv : ref_win[so + i];
      if (len == 0)            exp_done = 1;
      else if (m == MODE_FILL) exp_done = len + 1;
      else                     exp_done = 2 * len + 1;
      run_cmd(m, WIN_BASE + AW'(so), WIN_BASE + AW'(dof), AW'(len), fv, dc, wr, bc);
      check($sformatf("rand%0d_done_cycle", n), 32'(dc), 32'(exp_done));
      check($sformatf("rand%0d_writes", n), 32'(wr), 32'(len));
      for (int k = 0; k < 64; k++) begin
        a = WIN_BASE + AW'(k);
        check($sformatf("rand%0d_mem_0x%05h", n, a), 32'(mem[a]), 32'(ref_win[k]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
